// File: rtl/tb_ckt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ckt_pkg
// Description : Shared types and constants for the benchmark-netlist harness.
//               These cover the response width, the MISR defaults and the
//               compactor state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tb_ckt_pkg;

  // Netlist output count; the pattern generator and wrappers use it too.
  localparam int RESP_WIDTH = 32;

  // CRC-32 polynomial used as MISR feedback, and the all-ones start value.
  localparam logic [RESP_WIDTH-1:0] MISR_POLY_DEFAULT = 32'h04C11DB7;
  localparam logic [RESP_WIDTH-1:0] MISR_SEED_DEFAULT = 32'hFFFFFFFF;

  // Compactor control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } misr_state_t;

endpackage : tb_ckt_pkg
`default_nettype wire

// File: rtl/misr_core.sv
`default_nettype none
// ============================================================================
// Module      : misr_core
// Description : Signature register for the response compactor. It loads the
//               seed on request, or folds one input vector per step using
//               shift-left, polynomial feedback and XOR with the data.
// Revision    : 1.0 - initial release
// ============================================================================
module misr_core #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7,
  parameter logic [WIDTH-1:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [WIDTH-1:0] shift_w;

  // The feedback taps apply only when the bit shifted out of the MSB is 1.
  // Loading the seed takes priority over a step.
  always_comb begin
    shift_w = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0);
    sig_d   = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (step_i) begin
      sig_d = shift_w ^ data_i;
    end
  end

  // Signature register; reset clears it so an aborted run leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule : misr_core
`default_nettype wire

// File: rtl/response_misr.sv
`default_nettype none
// ============================================================================
// Module      : response_misr
// Description : Response compactor. It folds a programmed number of 32-bit
//               netlist output vectors into a MISR, then compares the result
//               with a golden signature and reports pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module response_misr
  import tb_ckt_pkg::*;
#(
  parameter int               WIDTH   = RESP_WIDTH,
  parameter logic [WIDTH-1:0] POLY    = MISR_POLY_DEFAULT,
  parameter logic [WIDTH-1:0] SEED    = MISR_SEED_DEFAULT,
  parameter int               COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_vectors,
  input  logic [WIDTH-1:0]   golden,
  input  logic               resp_valid,
  output logic               resp_ready,
  input  logic [WIDTH-1:0]   resp_data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [WIDTH-1:0]   signature,
  output logic [COUNT_W-1:0] vec_count
);

  localparam logic [COUNT_W-1:0] C_COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  misr_state_t        state_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] num_q;
  logic [WIDTH-1:0]   golden_q;
  logic               pass_q;

  logic               launch_w;
  logic               accept_w;
  logic               last_w;

  // A start only counts when the block is idle or finished; a start during
  // RUN or CHECK is dropped so that the latched run parameters survive.
  assign launch_w = start && ((state_q == IDLE) || (state_q == DONE));
  assign accept_w = resp_valid && resp_ready;
  assign last_w   = (count_q == (num_q - C_COUNT_ONE));

  // Control FSM with the vector counter, the run parameter latches and the
  // pass flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      num_q    <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            count_q  <= '0;
            num_q    <= num_vectors;
            golden_q <= golden;
            pass_q   <= 1'b0;
            state_q  <= (num_vectors == '0) ? CHECK : RUN;
          end
        end
        RUN: begin
          if (accept_w) begin
            count_q <= count_q + C_COUNT_ONE;
            if (last_w) begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          pass_q  <= (signature == golden_q);
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status decode comes straight from the state register, so it is
  // glitch-free and does not depend on resp_valid.
  assign resp_ready = (state_q == RUN);
  assign busy       = (state_q == RUN) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign vec_count  = count_q;

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (launch_w),
    .step_i (accept_w),
    .data_i (resp_data),
    .sig_o  (signature)
  );

endmodule : response_misr
`default_nettype wire

// File: tb/tb_response_misr.sv
`default_nettype none
// ============================================================================
// Module      : tb_response_misr
// Description : Directed self-checking bench for response_misr, using
//               hand-computed CRC-32 MISR signatures.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_response_misr;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_vectors;
  logic [31:0] golden;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] signature;
  logic [15:0] vec_count;

  int checks = 0;
  int errors = 0;

  response_misr dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vectors (num_vectors),
    .golden      (golden),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .signature   (signature),
    .vec_count   (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a single-cycle start; the FSM has left IDLE/DONE on return.
  task automatic kick(input logic [15:0] n, input logic [31:0] g);
    start       = 1'b1;
    num_vectors = n;
    golden      = g;
    tick();
    start       = 1'b0;
  endtask

  // Present one vector for a single cycle; resp_ready must be high that cycle.
  task automatic send(input logic [31:0] d);
    resp_valid = 1'b1;
    resp_data  = d;
    tick();
    resp_valid = 1'b0;
    resp_data  = 32'hDEADBEEF;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_vectors = '0;
    golden      = '0;
    resp_valid  = 1'b0;
    resp_data   = '0;

    // Reset state
    #2;
    check("rst_ready", {31'd0, resp_ready}, 32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_done",  {31'd0, done},       32'd0);
    check("rst_pass",  {31'd0, pass},       32'd0);
    check("rst_sig",   signature,           32'd0);
    check("rst_cnt",   {16'd0, vec_count},  32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single zero vector
    kick(16'd1, 32'hFB3EE249);
    check("t1_ready",  {31'd0, resp_ready}, 32'd1);
    check("t1_busy",   {31'd0, busy},       32'd1);
    check("t1_seed",   signature,           32'hFFFFFFFF);
    check("t1_cnt0",   {16'd0, vec_count},  32'd0);
    send(32'h0);
    check("t1_chk_rdy", {31'd0, resp_ready}, 32'd0);
    check("t1_chk_busy", {31'd0, busy},     32'd1);
    check("t1_chk_done", {31'd0, done},     32'd0);
    check("t1_sig",    signature,           32'hFB3EE249);
    check("t1_cnt",    {16'd0, vec_count},  32'd1);
    tick();
    check("t1_done",   {31'd0, done},       32'd1);
    check("t1_pass",   {31'd0, pass},       32'd1);
    check("t1_busy_d", {31'd0, busy},       32'd0);
    tick();
    check("t1_hold_sig", signature,         32'hFB3EE249);
    check("t1_hold_pass", {31'd0, pass},    32'd1);

    // Two zero vectors, restarted directly from DONE
    kick(16'd2, 32'h00000000);
    check("t2_done_clr", {31'd0, done},     32'd0);
    check("t2_pass_clr", {31'd0, pass},     32'd0);
    send(32'h0);
    check("t2_ready_mid", {31'd0, resp_ready}, 32'd1);
    send(32'h0);
    check("t2_ready_end", {31'd0, resp_ready}, 32'd0);
    tick();
    check("t2_done",   {31'd0, done},       32'd1);
    check("t2_pass",   {31'd0, pass},       32'd0);
    check("t2_sig",    signature,           32'hF2BCD925);
    check("t2_cnt",    {16'd0, vec_count},  32'd2);

    // Zero-length run
    kick(16'd0, 32'hFFFFFFFF);
    check("t3_ready",  {31'd0, resp_ready}, 32'd0);
    check("t3_busy",   {31'd0, busy},       32'd1);
    check("t3_done0",  {31'd0, done},       32'd0);
    tick();
    check("t3_done",   {31'd0, done},       32'd1);
    check("t3_pass",   {31'd0, pass},       32'd1);
    check("t3_sig",    signature,           32'hFFFFFFFF);
    check("t3_cnt",    {16'd0, vec_count},  32'd0);

    // Backpressure gap of 5 idle cycles, with garbage on resp_data
    kick(16'd1, 32'h00000000);
    resp_data = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_gap_sig", signature,          32'hFFFFFFFF);
      check("t4_gap_cnt", {16'd0, vec_count}, 32'd0);
    end
    send(32'hFB3EE249);
    check("t4_sig",    signature,           32'h00000000);
    check("t4_cnt",    {16'd0, vec_count},  32'd1);
    tick();
    check("t4_done",   {31'd0, done},       32'd1);
    check("t4_pass",   {31'd0, pass},       32'd1);

    // A start during RUN must not disturb the latched parameters
    kick(16'd2, 32'hF2BCD925);
    send(32'h0);
    kick(16'd5, 32'h00000000);
    check("t5_ign_busy", {31'd0, busy},     32'd1);
    check("t5_ign_cnt",  {16'd0, vec_count}, 32'd1);
    check("t5_ign_sig",  signature,         32'hFB3EE249);
    send(32'h0);
    check("t5_ign_chk",  {31'd0, resp_ready}, 32'd0);
    tick();
    check("t5_ign_done", {31'd0, done},     32'd1);
    check("t5_ign_pass", {31'd0, pass},     32'd1);
    check("t5_ign_cnt2", {16'd0, vec_count}, 32'd2);

    // Restart after done
    kick(16'd1, 32'hFB3EE249);
    check("t5_rs_done", {31'd0, done},      32'd0);
    check("t5_rs_pass", {31'd0, pass},      32'd0);
    check("t5_rs_seed", signature,          32'hFFFFFFFF);
    send(32'h0);
    tick();
    check("t5_rs_done2", {31'd0, done},     32'd1);
    check("t5_rs_pass2", {31'd0, pass},     32'd1);

    // Asynchronous reset mid-run, with no clock edge in between
    kick(16'd3, 32'h00000000);
    send(32'h0);
    #1;
    rst = 1'b1;
    #1;
    check("t6_ready",  {31'd0, resp_ready}, 32'd0);
    check("t6_busy",   {31'd0, busy},       32'd0);
    check("t6_done",   {31'd0, done},       32'd0);
    check("t6_pass",   {31'd0, pass},       32'd0);
    check("t6_sig",    signature,           32'd0);
    check("t6_cnt",    {16'd0, vec_count},  32'd0);
    tick();
    rst = 1'b0;
    resp_valid = 1'b1;
    tick();
    check("t6_idle_rdy",  {31'd0, resp_ready}, 32'd0);
    check("t6_idle_busy", {31'd0, busy},       32'd0);
    check("t6_idle_cnt",  {16'd0, vec_count},  32'd0);
    resp_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_response_misr
`default_nettype wire
